// File: rtl/data_mem_responder.sv
// ============================================================================
// data_mem_responder
// ----------------------------------------------------------------------------
// Data-memory responder for the CPU's memory port: a 256 x 16 RAM with
// synchronous write and asynchronous (combinational) read. A byte-wide
// valid/ready loader assembles little-endian 16-bit words and writes them to
// sequential addresses. The loader only writes on cycles where the CPU does
// not.
//
// Ports:
//   clk       in   1   system clock, rising edge
//   rst_n     in   1   asynchronous active-low reset
//   mem_we    in   1   CPU write enable
//   mem_addr  in   8   CPU word address (read and write)
//   mem_in    in  16   CPU write data
//   mem_out   out 16   read data, combinational from mem_addr
//   ld_start  in   1   loader restart (address 0, partial word dropped)
//   ld_valid  in   1   loader byte valid
//   ld_byte   in   8   loader byte
//   ld_ready  out  1   loader can accept a byte this cycle
//   ld_addr   out  8   address the next assembled word is written to
//   ld_busy   out  1   partial or pending word held
//
// Build option:
//   DATA_MEM_CLEAR_EN  when defined, reset clears every RAM word to 0x0000.
//                      When undefined the RAM is not reset.
//
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module data_mem_responder (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_we,
   input  logic [7:0]  mem_addr,
   input  logic [15:0] mem_in,
   output logic [15:0] mem_out,
   input  logic        ld_start,
   input  logic        ld_valid,
   input  logic [7:0]  ld_byte,
   output logic        ld_ready,
   output logic [7:0]  ld_addr,
   output logic        ld_busy
);

   localparam int unsigned DEPTH = 256;

   // Loader states: LO waits for the low byte, HI for the high byte,
   // WR holds the assembled word until the RAM write port is free.
   typedef enum logic [1:0] {
      S_LO = 2'd0,
      S_HI = 2'd1,
      S_WR = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  ld_addr_q, ld_addr_d;
   logic [7:0]  lo_q, lo_d;
   logic [7:0]  hi_q, hi_d;
   logic        ld_wr_en;
   logic        ld_hs;

   logic [15:0] ram_q [0:DEPTH-1];

   // ------------------------------------------------------------------------
   // Handshake and status outputs
   // ------------------------------------------------------------------------
   // rst_n is folded in so ready drops immediately on reset assertion and
   // rises combinationally on release.
   assign ld_ready = rst_n && !ld_start && (state_q != S_WR);
   assign ld_hs    = ld_valid && ld_ready;
   assign ld_busy  = (state_q != S_LO);
   assign ld_addr  = ld_addr_q;

   // ------------------------------------------------------------------------
   // Loader next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      ld_addr_d = ld_addr_q;
      lo_d      = lo_q;
      hi_d      = hi_q;
      ld_wr_en  = 1'b0;

      if (ld_start) begin
         // Restart wins over everything, including a pending WR write.
         state_d   = S_LO;
         ld_addr_d = 8'h00;
         lo_d      = 8'h00;
         hi_d      = 8'h00;
      end else begin
         unique case (state_q)
            S_LO: begin
               if (ld_hs) begin
                  lo_d    = ld_byte;
                  state_d = S_HI;
               end
            end
            S_HI: begin
               if (ld_hs) begin
                  hi_d    = ld_byte;
                  state_d = S_WR;
               end
            end
            S_WR: begin
               // The CPU always owns the write port; stall for as long as
               // it keeps writing.
               if (!mem_we) begin
                  ld_wr_en  = 1'b1;
                  ld_addr_d = ld_addr_q + 8'd1;
                  state_d   = S_LO;
               end
            end
            default: begin
               state_d = S_LO;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Loader state registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_LO;
         ld_addr_q <= 8'h00;
         lo_q      <= 8'h00;
         hi_q      <= 8'h00;
      end else begin
         state_q   <= state_d;
         ld_addr_q <= ld_addr_d;
         lo_q      <= lo_d;
         hi_q      <= hi_d;
      end
   end

   // ------------------------------------------------------------------------
   // RAM array: CPU write has priority; the loader write is only enabled
   // when mem_we is low, so the two never collide.
   // ------------------------------------------------------------------------
`ifdef DATA_MEM_CLEAR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            ram_q[i] <= 16'h0000;
         end
      end else if (mem_we) begin
         ram_q[mem_addr] <= mem_in;
      end else if (ld_wr_en) begin
         ram_q[ld_addr_q] <= {hi_q, lo_q};
      end
   end
`else
   always_ff @(posedge clk) begin
      if (mem_we) begin
         ram_q[mem_addr] <= mem_in;
      end else if (ld_wr_en) begin
         ram_q[ld_addr_q] <= {hi_q, lo_q};
      end
   end
`endif

   // Asynchronous read: shows the pre-edge contents during a write cycle.
   assign mem_out = ram_q[mem_addr];

endmodule

`default_nettype wire
